// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with a one-entry skid buffer and IF/ID pipeline register.
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   stall         hazard stall from ID; holds PC and IF/ID
//   pc_src        taken branch from EX; load branch_target (beats stall)
//   branch_target branch destination
//   jump          jump decoded for the instruction sitting in instr_D
//   imem_req      fetch request (FETCH state, out of reset)
//   imem_addr     fetch address (the current PC)
//   imem_ready    instruction memory data valid this cycle
//   imem_rdata    fetched instruction word
//   instr_D       IF/ID instruction
//   pc_plus4_D    IF/ID PC+4
//   op_D          instr_D[31:26]
//   valid_D       IF/ID holds a real instruction (0 = bubble)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    input  logic        jump,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_plus4_D,
    output logic [5:0]  op_D,
    output logic        valid_D
);
    typedef enum logic {FETCH, HOLD} stateT;

    stateT       state;
    logic [31:0] pc;
    logic [31:0] skid;
    logic [31:0] pcPlus4;
    logic [31:0] jumpTarget;

    assign pcPlus4    = pc + 32'd4;
    assign jumpTarget = {pc_plus4_D[31:28], instr_D[25:0], 2'b00};
    assign imem_addr  = pc;
    assign op_D       = instr_D[31:26];
    // Gating with reset keeps the request low during reset without waiting for a clock.
    assign imem_req   = reset && (state == FETCH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            skid       <= 32'h0;
            instr_D    <= 32'h0;
            pc_plus4_D <= 32'h0;
            valid_D    <= 1'b0;
        end else if (pc_src || (jump && !stall)) begin
            // Redirect: any in-flight or skidded word belongs to the wrong path.
            state   <= FETCH;
            pc      <= pc_src ? branch_target : jumpTarget;
            skid    <= 32'h0;
            instr_D <= 32'h0;
            valid_D <= 1'b0;
        end else if (state == HOLD) begin
            if (!stall) begin
                state      <= FETCH;
                pc         <= pcPlus4;
                instr_D    <= skid;
                pc_plus4_D <= pcPlus4;
                valid_D    <= 1'b1;
            end
        end else if (imem_ready && stall) begin
            // Park the word; HOLD drops the request so this address is not re-fetched.
            state <= HOLD;
            skid  <= imem_rdata;
        end else if (imem_ready) begin
            pc         <= pcPlus4;
            instr_D    <= imem_rdata;
            pc_plus4_D <= pcPlus4;
            valid_D    <= 1'b1;
        end else if (!stall) begin
            instr_D <= 32'h0;
            valid_D <= 1'b0;
        end
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded at reset.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: stall  in  1  hazard stall from ID; holds PC and the IF/ID register.
REQ-005 SHALL have port: pc_src  in  1  branch taken, resolved in EX.
REQ-006 SHALL have port: branch_target  in  32  branch destination.
REQ-007 SHALL have port: jump  in  1  jump decoded for the instruction currently in instr_D.
REQ-008 SHALL have port: imem_req  out  1  fetch request to instruction memory.
REQ-009 SHALL have port: imem_addr  out  32  fetch address, equal to the current PC.
REQ-010 SHALL have port: imem_ready  in  1  instruction memory data valid this cycle.
REQ-011 SHALL have port: imem_rdata  in  32  fetched instruction word.
REQ-012 SHALL have port: instr_D  out  32  IF/ID instruction register.
REQ-013 SHALL have port: pc_plus4_D  out  32  IF/ID PC+4 register.
REQ-014 SHALL have port: op_D  out  6  instr_D[31:26]; drives the main decoder op input.
REQ-015 SHALL have port: valid_D  out  1  1 = instr_D holds a real instruction; 0 = bubble.

Function
REQ-016 SHALL implement a two-state FSM: FETCH (imem_req=1) and HOLD (imem_req=0; fetched word kept in an internal 32-bit skid buffer).
REQ-017 SHALL drive imem_addr = PC in every cycle; PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-018 SHALL compute the jump target internally as {pc_plus4_D[31:28], instr_D[25:0], 2'b00}.
REQ-019 SHALL apply redirect priority: pc_src > (jump && !stall) > sequential.
REQ-020 SHALL, when pc_src=1 in any state, load PC <= branch_target, write a bubble into IF/ID, discard any skid data, and enter FETCH; this overrides stall.
REQ-021 SHALL, when jump=1 and stall=0 with pc_src=0, load PC <= jump target, write a bubble into IF/ID, discard any skid data, and enter FETCH.
REQ-022 SHALL ignore jump while stall=1; the jump instruction stays in ID.
REQ-023 SHALL, in FETCH with imem_ready=1, stall=0, and no redirect, load IF/ID <= {imem_rdata, PC+4, valid=1} and PC <= PC+4.
REQ-024 SHALL, in FETCH with imem_ready=1, stall=1, and no redirect, capture imem_rdata into the skid buffer, hold PC and IF/ID, and enter HOLD.
REQ-025 SHALL, in FETCH with imem_ready=0, stall=0, and no redirect, hold PC, write a bubble into IF/ID, and remain in FETCH.
REQ-026 SHALL, in FETCH with imem_ready=0 and stall=1, hold PC and IF/ID.
REQ-027 SHALL, in HOLD with stall=0 and no redirect, load IF/ID <= {skid, PC+4, valid=1}, set PC <= PC+4, and enter FETCH.
REQ-028 SHALL, in HOLD with stall=1 and no redirect, hold all state.
REQ-029 SHALL define a bubble as instr_D=32'h0, pc_plus4_D unchanged, and valid_D=0.
REQ-030 SHALL achieve one-cycle fetch latency: a word accepted at edge N appears on instr_D/op_D after edge N.
REQ-031 SHALL never issue a second request for an address whose word is held in the skid buffer.

Reset
REQ-032 SHALL, on reset=0 and without waiting for clk, force PC=RESET_PC, state=FETCH, instr_D=0, pc_plus4_D=0, valid_D=0, and skid=0.
REQ-033 SHALL, while reset=0, hold imem_req=0.
REQ-034 SHALL, on the first edge after reset deasserts, have imem_req=1 and imem_addr=RESET_PC.
REQ-035 SHALL, when reset asserts mid-fetch or in HOLD, abandon the fetch; the memory response is ignored.

Verification
REQ-036 SHALL verify sequential fetch: imem_ready=1 for 4 cycles, words A0..A3 -> imem_addr 0,4,8,C; instr_D=A0..A3; pc_plus4_D 4..10; valid_D=1.
REQ-037 SHALL verify stall/skid: stall=1 in the cycle word W@8 returns -> HOLD, imem_req=0 for 3 stall cycles; on release instr_D=W, pc_plus4_D=C, and the next imem_addr is C.
REQ-038 SHALL verify branch over stall: pc_src=1, branch_target=40, stall=1 in HOLD -> next cycle imem_addr=40, valid_D=0, and the skid word is never delivered.
REQ-039 SHALL verify jump: instr_D=08000010, pc_plus4_D=4, stall=0 -> imem_addr=40, bubble in IF/ID; the same with stall=1 -> PC unchanged.
REQ-040 SHALL verify memory wait: imem_ready=0 for 2 cycles -> imem_addr constant and valid_D=0 both cycles; then the word is delivered once.
REQ-041 SHALL verify async reset and wrap: reset=0 pulsed between edges -> outputs clear immediately; PC=FFFF_FFFC fetch -> pc_plus4_D=0 and next imem_addr=0.
